// File: rtl/hash_tbl_pkg.sv
// Shared definitions for the linear-probing hash table and its host-side initiator.
//   - command codes carried on req_cmd / tbl_cmd
//   - status codes returned by the table and on rsp_status
//   - initiator state encoding
//   - bucket_hash(): 3-bit bucket index of a 4-bit key
package hash_tbl_pkg;

    localparam logic [1:0] CMD_LOOKUP = 2'd0;
    localparam logic [1:0] CMD_INSERT = 2'd1;
    localparam logic [1:0] CMD_DELETE = 2'd2;
    localparam logic [1:0] CMD_BAD    = 2'd3;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_FULL     = 2'd1;
    localparam logic [1:0] STATUS_NOTFOUND = 2'd2;
    localparam logic [1:0] STATUS_BUSY     = 2'd3;
    // The initiator reuses the table's BUSY code to report an illegal command.
    localparam logic [1:0] STATUS_BAD_CMD  = STATUS_BUSY;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } init_state_e;

    // Fold the key's top bit into the low bucket bit.
    function automatic logic [2:0] bucket_hash(input logic [3:0] key);
        return key[2:0] ^ {2'b00, key[3]};
    endfunction

endpackage

// File: rtl/hash_cmd_initiator.sv
// Host-side initiator for the linear-probing hash table.
// Accepts one LOOKUP/INSERT/DELETE request at a time, drives the table's
// go/cmd/key/val/hash inputs, waits a fixed worst-case latency (the table has
// no done flag), then returns the table's status/data on a response channel.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset (shared with the table)
//   req_valid/req_ready        request handshake; req_ready is high only in IDLE
//   req_cmd/req_key/req_val    command (0 LOOKUP, 1 INSERT, 2 DELETE, 3 illegal), key, value
//   rsp_valid/rsp_ready        response handshake; rsp_valid held until rsp_ready
//   rsp_status/rsp_data        0 OK, 1 FULL, 2 NOTFOUND, 3 BAD_CMD; data only for LOOKUP+OK
//   tbl_go                     one-cycle start pulse to the table
//   tbl_cmd/key/val/hash       operands, held stable from ISSUE through RESP
//   tbl_status/tbl_out         table result, sampled at the end of the wait window
module hash_cmd_initiator
    import hash_tbl_pkg::*;
#(
    // Cycles spent in WAIT after the go cycle; must be >= 10
    // (8 probes + loop detection + 1 cycle for the result to settle).
    parameter int WAIT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [3:0] req_key,
    input  logic [3:0] req_val,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_status,
    output logic [3:0] rsp_data,
    output logic       tbl_go,
    output logic [1:0] tbl_cmd,
    output logic [3:0] tbl_key,
    output logic [3:0] tbl_val,
    output logic [2:0] tbl_hash,
    input  logic [1:0] tbl_status,
    input  logic [3:0] tbl_out
);

    localparam int               CNT_W     = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_CYCLES);

    init_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req_ready_d;
    logic             rsp_valid_d;
    logic [1:0]       rsp_status_d;
    logic [3:0]       rsp_data_d;
    logic             tbl_go_d;
    logic [1:0]       tbl_cmd_d;
    logic [3:0]       tbl_key_d;
    logic [3:0]       tbl_val_d;
    logic [2:0]       tbl_hash_d;

    // Next-state and next-output logic; every output is the registered copy
    // of its *_d value.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready;
        rsp_valid_d  = rsp_valid;
        rsp_status_d = rsp_status;
        rsp_data_d   = rsp_data;
        tbl_go_d     = 1'b0;      // a pulse: never held, a held go restarts the table
        tbl_cmd_d    = tbl_cmd;
        tbl_key_d    = tbl_key;
        tbl_val_d    = tbl_val;
        tbl_hash_d   = tbl_hash;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    tbl_cmd_d   = req_cmd;
                    tbl_key_d   = req_key;
                    tbl_val_d   = req_val;
                    tbl_hash_d  = bucket_hash(req_key);
                    req_ready_d = 1'b0;
                    if (req_cmd == CMD_BAD) begin
                        // Illegal command never reaches the table.
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = STATUS_BAD_CMD;
                        rsp_data_d   = 4'd0;
                    end else begin
                        state_d  = ST_ISSUE;
                        tbl_go_d = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                // The table samples go at the edge ending this cycle.
                state_d = ST_WAIT;
                cnt_d   = CNT_FIRST;
            end

            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d      = ST_RESP;
                    cnt_d        = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = tbl_status;
                    rsp_data_d   = (tbl_cmd == CMD_LOOKUP && tbl_status == STATUS_OK)
                                   ? tbl_out : 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= 2'd0;
            rsp_data   <= 4'd0;
            tbl_go     <= 1'b0;
            tbl_cmd    <= 2'd0;
            tbl_key    <= 4'd0;
            tbl_val    <= 4'd0;
            tbl_hash   <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_status <= rsp_status_d;
            rsp_data   <= rsp_data_d;
            tbl_go     <= tbl_go_d;
            tbl_cmd    <= tbl_cmd_d;
            tbl_key    <= tbl_key_d;
            tbl_val    <= tbl_val_d;
            tbl_hash   <= tbl_hash_d;
        end
    end

endmodule

// File: tb/tb_hash_cmd_initiator.sv
// Bench for hash_cmd_initiator: directed scenarios with literal expectations,
// then randomized traffic. A behavioural 8-slot probing table answers tbl_go,
// and a per-cycle scoreboard checks handshake timing, the go pulse, operand
// hold and the response against the table's result.
module tb_hash_cmd_initiator;
    import hash_tbl_pkg::*;

    localparam int WAIT_CYCLES = 10;
    localparam int LAT_LEGAL   = WAIT_CYCLES + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, rsp_valid, rsp_ready, tbl_go;
    logic [1:0] req_cmd, rsp_status, tbl_cmd, tbl_status;
    logic [3:0] req_key, req_val, rsp_data, tbl_key, tbl_val, tbl_out;
    logic [2:0] tbl_hash;

    hash_cmd_initiator #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_key(req_key), .req_val(req_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data),
        .tbl_go(tbl_go), .tbl_cmd(tbl_cmd), .tbl_key(tbl_key),
        .tbl_val(tbl_val), .tbl_hash(tbl_hash),
        .tbl_status(tbl_status), .tbl_out(tbl_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- behavioural probing table ----------------
    logic [3:0] slot_k [8];
    logic [3:0] slot_v [8];
    logic       slot_u [8];
    int         t_rem;
    logic [1:0] done_st;
    logic [3:0] done_out;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] idx;
        logic [3:0] probes;
    } tres_t;

    // Walk all 8 buckets starting at h; earliest hit wins. A miss costs the
    // full loop (9 cycles), a hit at probe p costs p+1.
    function automatic tres_t tbl_eval(input logic [1:0] c, input logic [3:0] k, input logic [2:0] h);
        tres_t      r;
        logic [2:0] s;
        r.st     = (c == CMD_INSERT) ? STATUS_FULL : STATUS_NOTFOUND;
        r.idx    = 3'd0;
        r.probes = 4'd9;
        for (int p = 7; p >= 0; p--) begin
            s = h + 3'(p);
            if ((c == CMD_INSERT) ? !slot_u[s] : (slot_u[s] && slot_k[s] == k)) begin
                r.st     = STATUS_OK;
                r.idx    = s;
                r.probes = 4'(p + 1);
            end
        end
        return r;
    endfunction

    tres_t t_now;
    always_comb t_now = tbl_eval(tbl_cmd, tbl_key, tbl_hash);

    // While busy the table shows BUSY and junk data, so an early sample is visible.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) slot_u[i] <= 1'b0;
            t_rem      <= 0;
            tbl_status <= STATUS_OK;
            tbl_out    <= 4'd0;
            done_st    <= STATUS_OK;
            done_out   <= 4'd0;
        end else if (tbl_go) begin
            t_rem      <= int'(t_now.probes);
            tbl_status <= STATUS_BUSY;
            tbl_out    <= 4'($urandom_range(1, 15));
        end else if (t_rem > 0) begin
            t_rem <= t_rem - 1;
            if (t_rem == 1) begin
                tbl_status <= t_now.st;
                tbl_out    <= (tbl_cmd == CMD_LOOKUP && t_now.st == STATUS_OK)
                              ? slot_v[t_now.idx] : 4'($urandom_range(1, 15));
                done_st    <= t_now.st;
                done_out   <= slot_v[t_now.idx];
                if (t_now.st == STATUS_OK && tbl_cmd == CMD_INSERT) begin
                    slot_u[t_now.idx] <= 1'b1;
                    slot_k[t_now.idx] <= tbl_key;
                    slot_v[t_now.idx] <= tbl_val;
                end
                if (t_now.st == STATUS_OK && tbl_cmd == CMD_DELETE)
                    slot_u[t_now.idx] <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle scoreboard ----------------
    initial begin
        bit         rst_pend = 1'b1;
        bit         busy     = 1'b0;
        int         age      = 0;
        int         lat      = 0;
        logic [1:0] c        = 2'd0;
        logic [3:0] k        = 4'd0;
        logic [3:0] v        = 4'd0;
        logic [1:0] est;
        logic [3:0] edat;
        forever begin
            @(negedge clk);
            if (rst_pend) begin
                chk("rst_req_ready",  32'(req_ready),  32'(1));
                chk("rst_tbl_go",     32'(tbl_go),     32'(0));
                chk("rst_rsp_valid",  32'(rsp_valid),  32'(0));
                chk("rst_rsp_status", 32'(rsp_status), 32'(0));
                chk("rst_rsp_data",   32'(rsp_data),   32'(0));
                chk("rst_tbl_cmd",    32'(tbl_cmd),    32'(0));
                chk("rst_tbl_key",    32'(tbl_key),    32'(0));
                chk("rst_tbl_val",    32'(tbl_val),    32'(0));
                chk("rst_tbl_hash",   32'(tbl_hash),   32'(0));
                busy     = 1'b0;
                rst_pend = 1'b0;
            end else begin
                if (busy) age++;
                chk("req_ready", 32'(req_ready), 32'(!busy));
                chk("tbl_go",    32'(tbl_go),    32'(busy && c != CMD_BAD && age == 1));
                chk("rsp_valid", 32'(rsp_valid), 32'(busy && age >= lat));
                if (busy && age >= 1) begin
                    chk("tbl_cmd_hold",  32'(tbl_cmd),  32'(c));
                    chk("tbl_key_hold",  32'(tbl_key),  32'(k));
                    chk("tbl_val_hold",  32'(tbl_val),  32'(v));
                    chk("tbl_hash_hold", 32'(tbl_hash), 32'(3'((k % 8) ^ (k / 8))));
                end
                if (busy && age >= lat) begin
                    if (c == CMD_BAD) begin
                        est  = STATUS_BAD_CMD;
                        edat = 4'd0;
                    end else begin
                        est  = done_st;
                        edat = (c == CMD_LOOKUP && done_st == STATUS_OK) ? done_out : 4'd0;
                    end
                    chk("rsp_status", 32'(rsp_status), 32'(est));
                    chk("rsp_data",   32'(rsp_data),   32'(edat));
                end
            end
            if (!rst_n) begin
                rst_pend = 1'b1;
            end else if (busy && age >= lat && rsp_ready) begin
                busy = 1'b0;
            end else if (!busy && req_valid) begin
                busy = 1'b1;
                age  = 0;
                c    = req_cmd;
                k    = req_key;
                v    = req_val;
                lat  = (req_cmd == CMD_BAD) ? 1 : LAT_LEGAL;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One request/response transaction. 'noisy' scribbles on req_* and
    // rsp_ready while the op is in flight; those must be ignored.
    task automatic do_op(input logic [1:0] c, input logic [3:0] k, input logic [3:0] v,
                         input int hold, input bit noisy,
                         output logic [1:0] st, output logic [3:0] d, output int lat);
        int guard = 0;
        st  = 2'd0;
        d   = 4'd0;
        lat = 0;
        req_cmd   = c;
        req_key   = k;
        req_val   = v;
        req_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            guard++;
            if (guard > 50) begin
                timeout_fail("req_accept");
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        req_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) begin
            req_cmd = 2'($urandom);
            req_key = 4'($urandom);
            req_val = 4'($urandom);
        end
        forever begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (lat > 40) begin
                timeout_fail("rsp_valid");
                req_valid = 1'b0;
                rsp_ready = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (noisy) rsp_ready = 1'($urandom_range(0, 1));
        end
        st = rsp_status;
        d  = rsp_data;
        if (!rsp_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_rsp_valid", 32'(rsp_valid), 32'(1));
                chk("hold_req_ready", 32'(req_ready), 32'(0));
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] st;
        logic [3:0] d;
        int         lat;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 2'd0;
        req_key   = 4'd0;
        req_val   = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: insert into empty table
        do_op(CMD_INSERT, 4'd5, 4'd9, 0, 0, st, d, lat);
        chk("t1_status", 32'(st), 32'(0));
        chk("t1_data",   32'(d),  32'(0));
        chk("t1_lat",    32'(lat), 32'(12));

        // 2: lookups hit and miss
        do_op(CMD_LOOKUP, 4'd5, 4'd0, 0, 0, st, d, lat);
        chk("t2_hit_status", 32'(st), 32'(0));
        chk("t2_hit_data",   32'(d),  32'(9));
        do_op(CMD_LOOKUP, 4'd6, 4'd0, 0, 0, st, d, lat);
        chk("t2_miss_status", 32'(st), 32'(2));
        chk("t2_miss_data",   32'(d),  32'(0));

        // 3: fill table, then overflow
        do_op(CMD_DELETE, 4'd5, 4'd0, 0, 0, st, d, lat);
        chk("t3_clear_status", 32'(st), 32'(0));
        for (int i = 0; i < 8; i++) begin
            do_op(CMD_INSERT, 4'(i), 4'(i) ^ 4'hA, 0, 0, st, d, lat);
            chk("t3_fill_status", 32'(st), 32'(0));
        end
        do_op(CMD_INSERT, 4'd8, 4'd2, 0, 0, st, d, lat);
        chk("t3_full_status", 32'(st), 32'(1));
        chk("t3_full_lat",    32'(lat), 32'(12));
        do_op(CMD_LOOKUP, 4'd7, 4'd0, 0, 0, st, d, lat);
        chk("t3_lookup7_data", 32'(d), 32'(13));

        // 4: delete, miss, re-insert, hit
        do_op(CMD_DELETE, 4'd3, 4'd0, 0, 0, st, d, lat);
        chk("t4_del_status", 32'(st), 32'(0));
        do_op(CMD_LOOKUP, 4'd3, 4'd0, 0, 0, st, d, lat);
        chk("t4_miss_status", 32'(st), 32'(2));
        do_op(CMD_INSERT, 4'd3, 4'd1, 0, 0, st, d, lat);
        chk("t4_ins_status", 32'(st), 32'(0));
        do_op(CMD_LOOKUP, 4'd3, 4'd0, 0, 0, st, d, lat);
        chk("t4_hit_status", 32'(st), 32'(0));
        chk("t4_hit_data",   32'(d),  32'(1));

        // 5: illegal command
        do_op(CMD_BAD, 4'd4, 4'd4, 0, 0, st, d, lat);
        chk("t5_status", 32'(st), 32'(3));
        chk("t5_data",   32'(d),  32'(0));
        chk("t5_lat",    32'(lat), 32'(1));

        // 6a: response back-pressure
        do_op(CMD_LOOKUP, 4'd0, 4'd0, 5, 0, st, d, lat);
        chk("t6_status", 32'(st), 32'(0));
        chk("t6_data",   32'(d),  32'(10));

        // 6b: reset in the middle of WAIT abandons the op
        req_cmd   = CMD_INSERT;
        req_key   = 4'd9;
        req_val   = 4'd6;
        req_valid = 1'b1;
        @(negedge clk);
        chk("t6_req_ready", 32'(req_ready), 32'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t6_rst_no_rsp", 32'(rsp_valid), 32'(0));
            chk("t6_rst_no_go",  32'(tbl_go),    32'(0));
        end
        @(posedge clk); #1;
        do_op(CMD_LOOKUP, 4'd0, 4'd0, 0, 0, st, d, lat);
        chk("t6_table_cleared", 32'(st), 32'(2));

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [1:0] rc;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            rc = ($urandom_range(0, 11) == 0) ? CMD_BAD : 2'($urandom_range(0, 2));
            do_op(rc, 4'($urandom_range(0, 15)), 4'($urandom), $urandom_range(0, 3), 1,
                  st, d, lat);
            chk("rnd_lat", 32'(lat), 32'((rc == CMD_BAD) ? 1 : LAT_LEGAL));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
